tdm_demux10: RTL

//   Receive end of the 10-channel time-division link fed by the 10:1 mux path.

---
 rtl/tdm_demux10_if.sv | 29 ++
 rtl/tdm_demux10.sv | 94 +++++++++
 2 files changed

// File: rtl/tdm_demux10_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdm_demux10_if : serial TDM slot input and parallel frame output bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface tdm_demux10_if #(
  parameter int WIDTH = 1,
  parameter int NCH   = 10
);
  logic [WIDTH-1:0]         din;
  logic                     din_valid;
  logic                     frame_sync;
  logic [NCH*WIDTH-1:0]     dout;
  logic                     frame_valid;
  logic [$clog2(NCH)-1:0]   slot_idx;
  logic                     sync_err;
  logic                     locked;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, frame_valid, slot_idx, sync_err, locked
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, frame_valid, slot_idx, sync_err, locked
  );
endinterface
`default_nettype wire

// File: rtl/tdm_demux10.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdm_demux10 : frame-aligned TDM demux, serial slots to parallel channel word
// Revision 1.0
// ---------------------------------------------------------------------------
module tdm_demux10 #(
  parameter int WIDTH = 1,
  parameter int NCH   = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux10_if.slave   bus
);

  localparam int SW = $clog2(NCH);
  localparam int DW = NCH * WIDTH;

  typedef enum logic [0:0] {
    S_HUNT = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            fv_q, fv_d;
  logic            serr_q, serr_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;

    if (bus.din_valid) begin
      if (state_q == S_HUNT) begin
        if (bus.frame_sync) begin
          shadow_d[WIDTH-1:0] = bus.din;
          slot_d              = SW'(1);
          state_d             = S_RECV;
        end
      end else if (bus.frame_sync) begin
        // Sync mid-frame: drop the partial frame and restart at slot 0.
        serr_d              = 1'b1;
        shadow_d[WIDTH-1:0] = bus.din;
        slot_d              = SW'(1);
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (slot_q == SW'(k)) begin
            shadow_d[k*WIDTH +: WIDTH] = bus.din;
          end
        end
        if (slot_q == SW'(NCH-1)) begin
          // Last slot completes the frame; the next frame must begin with a sync.
          dout_d  = shadow_d;
          fv_d    = 1'b1;
          slot_d  = '0;
          state_d = S_HUNT;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = fv_q;
  assign bus.slot_idx    = slot_q;
  assign bus.sync_err    = serr_q;
  assign bus.locked      = (state_q == S_RECV);

endmodule
`default_nettype wire
